uart_tx_cfg: RTL

Next-generation UART transmit path: FIFO, baud-tick generator and serialiser in one block.
- Generalised over the current fixed 8N1 transmitter.
- Runtime-selectable baud divisor, parity mode and stop-bit count, plus a FIFO fill level output.
- Sits between a host write port and the serial pin, alongside the existing receiver.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tx_cfg_if.sv | 43 ++++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_cfg.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and width constants for the configurable UART transmitter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Per-frame configuration captured when a byte leaves the FIFO.
  typedef struct packed {
    logic par_en;
    logic stop2;
  } frame_cfg_t;

  localparam int DEPTH_DEF = 16;
  localparam int ADDR_W    = $clog2(DEPTH_DEF);
  localparam int PTR_W     = ADDR_W + 1;
  localparam int LVL_W     = ADDR_W + 1;

  // Width of a counter able to hold 0..d, also the wrap-bit pointer width.
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side bundle of the UART transmitter: config, write port, status, serial line.
// Latency: none, wires only.
// Backpressure: host must watch full; ovf exists only with UART_TX_OVF_EN.
interface uart_tx_cfg_if #(
  parameter int dbit  = 8,
  parameter int depth = 16,
  parameter int div_w = 16
);
  import uart_pkg::*;

  logic [div_w-1:0]        baud_div;
  logic [1:0]              parity_mode;
  logic                    stop2;
  logic                    wr;
  logic [dbit-1:0]         wr_data;
  logic                    full;
  logic                    empty;
  logic [cnt_w(depth)-1:0] level;
  logic                    busy;
  logic                    tx_out;
`ifdef UART_TX_OVF_EN
  logic                    ovf;

  modport master (
    output baud_div, parity_mode, stop2, wr, wr_data,
    input  full, empty, level, busy, tx_out, ovf
  );
  modport slave (
    input  baud_div, parity_mode, stop2, wr, wr_data,
    output full, empty, level, busy, tx_out, ovf
  );
`else
  modport master (
    output baud_div, parity_mode, stop2, wr, wr_data,
    input  full, empty, level, busy, tx_out
  );
  modport slave (
    input  baud_div, parity_mode, stop2, wr, wr_data,
    output full, empty, level, busy, tx_out
  );
`endif

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the serialiser, with registered full/empty/level.
// Latency: a pushed entry is visible at the head (empty=0) one clock after the push edge.
// Backpressure: push ignored while full; pop ignored while empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int dbit  = 8,
  parameter int depth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [dbit-1:0]         wr_data,
  output logic [dbit-1:0]         rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(depth)-1:0] level
);
  localparam int AW = $clog2(depth);
  localparam int PW = cnt_w(depth);

  logic [dbit-1:0] mem [depth];
  logic [PW-1:0]   wptr, rptr;
  logic [PW-1:0]   level_n;
  logic            do_push, do_pop;

  // Gating uses the registered flags, so a push while full is dropped even if a pop frees space.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rptr[AW-1:0]];

  // Next fill level; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_n = level;
    case ({do_push, do_pop})
      2'b10:   level_n = level + PW'(1);
      2'b01:   level_n = level - PW'(1);
      default: level_n = level;
    endcase
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      level <= level_n;
      full  <= (level_n == PW'(depth));
      empty <= (level_n == '0);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: FIFO, baud-tick generator and serialiser with runtime parity/stop/divisor; ovf output under UART_TX_OVF_EN.
// Latency: write accepted at edge n, byte popped at n+1, start bit on tx_out after n+2.
// Backpressure: writes while full are dropped (flagged on ovf when UART_TX_OVF_EN is defined).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int dbit  = 8,
  parameter int stick = 16,
  parameter int depth = 16,
  parameter int div_w = 16
) (
  input logic          clk,
  input logic          rst,
  uart_tx_cfg_if.slave bus
);
  localparam int LW = cnt_w(depth);
  localparam int SW = $clog2(2 * stick);
  localparam int BW = (dbit > 1) ? $clog2(dbit) : 1;

  tx_state_t        state, state_n;
  logic             pop, tick, bit_done, tx_d, tx_q, par_bit;
  logic [div_w-1:0] cnt, div_l;
  logic [SW-1:0]    s_cnt, s_lim;
  logic [BW-1:0]    bit_cnt;
  logic [dbit-1:0]  shreg, fifo_data;
  frame_cfg_t       cfg;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;

  uart_tx_fifo #(.dbit(dbit), .depth(depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.wr),
    .pop     (pop),
    .wr_data (bus.wr_data),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bus.full   = fifo_full;
  assign bus.empty  = fifo_empty;
  assign bus.level  = fifo_level;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.tx_out = tx_q;

  // The divisor is latched per frame so a mid-frame change cannot stretch a bit.
  assign tick     = (cnt == div_l);
  assign s_lim    = (state == ST_STOP && cfg.stop2) ? SW'(2 * stick - 1) : SW'(stick - 1);
  assign bit_done = tick && (s_cnt == s_lim);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state, FIFO pop and the unregistered line level for each state.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done) state_n = ST_DATA;
      end
      ST_DATA: begin
        tx_d = shreg[0];
        if (bit_done && bit_cnt == BW'(dbit - 1))
          state_n = cfg.par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_d = par_bit;
        if (bit_done) state_n = ST_STOP;
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Frame datapath: config capture at pop, tick/sample/bit counters, shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_l   <= '0;
      s_cnt   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      cfg     <= '0;
    end else if (pop) begin
      cnt        <= '0;
      div_l      <= bus.baud_div;
      s_cnt      <= '0;
      bit_cnt    <= '0;
      shreg      <= fifo_data;
      par_bit    <= (^fifo_data) ^ (bus.parity_mode == PAR_ODD);
      cfg.par_en <= (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
      cfg.stop2  <= bus.stop2;
    end else if (state != ST_IDLE) begin
      cnt <= tick ? '0 : cnt + div_w'(1);
      if (tick) begin
        s_cnt <= bit_done ? '0 : s_cnt + SW'(1);
        if (state == ST_DATA && bit_done) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  // Registered serial line; idles high and is forced high by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_q <= 1'b1;
    else     tx_q <= tx_d;
  end

`ifdef UART_TX_OVF_EN
  logic ovf_q;

  // Sticky record of any write dropped because the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ovf_q <= 1'b0;
    else if (bus.wr && fifo_full) ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
